// File: rtl/rec_player.sv
// rtl/rec_player.sv - note-record playback sequencer; optional inter-note gap via PLAY_GAP_EN
module rec_player #(
    parameter int OCT_W      = 2,
    parameter int NOTE_W     = 3,
    parameter int LEN_W      = 3,
    parameter int ADDR_W     = 5,
    parameter int GAP_CYCLES = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            play,
    input  logic                            stop,
    input  logic                            loop,
    input  logic [ADDR_W:0]                 rec_len,
    output logic                            rd_en,
    output logic [ADDR_W-1:0]               rd_addr,
    input  logic [OCT_W+NOTE_W+LEN_W:0]     rd_data,
    output logic                            snd_start,
    output logic                            snd_abort,
    output logic [OCT_W-1:0]                snd_octave,
    output logic [NOTE_W-1:0]               snd_note,
    output logic [LEN_W-1:0]                snd_length,
    input  logic                            snd_over,
    output logic                            busy,
    output logic                            done,
    output logic [ADDR_W-1:0]               cur_addr,
    output logic [6:0]                      note_led
);

    localparam int DW = 1 + OCT_W + NOTE_W + LEN_W;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;
    localparam logic [2:0] S_END   = 3'd5;

    logic [2:0]        state;
    logic [2:0]        state_nx;
    logic [ADDR_W-1:0] addr;
    logic              last_entry;
    logic              entry_valid;
    logic              aborting;

    // The entry just played is the last one when its successor index reaches rec_len.
    assign last_entry  = ({1'b0, addr} + {{ADDR_W{1'b0}}, 1'b1}) == rec_len;
    assign entry_valid = rd_data[DW-1];
    assign aborting    = stop && (state != S_IDLE);

    assign rd_en   = (state == S_FETCH);
    assign rd_addr = addr;
    assign busy    = (state != S_IDLE);
    // A stop landing in END suppresses the done pulse.
    assign done    = (state == S_END) && !stop;

`ifdef PLAY_GAP_EN
    localparam int GW = $clog2(GAP_CYCLES + 1);
    logic [GW-1:0] gap_cnt;
    logic          gap_last;

    assign gap_last = (gap_cnt == GW'(GAP_CYCLES - 1));

    // Gap counter restarts on every WAIT->GAP entry and runs only inside GAP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_cnt <= '0;
        end else if (state == S_GAP && !gap_last) begin
            gap_cnt <= gap_cnt + 1'b1;
        end else begin
            gap_cnt <= '0;
        end
    end
`endif

    // Next-state selection; stop overrides every other transition.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (play) begin
                    state_nx = (rec_len == '0) ? S_END : S_FETCH;
                end
            end
            S_FETCH: state_nx = S_LOAD;
            S_LOAD:  state_nx = entry_valid ? S_WAIT : S_END;
            S_WAIT: begin
                if (snd_over) begin
`ifdef PLAY_GAP_EN
                    state_nx = last_entry ? S_END : S_GAP;
`else
                    state_nx = last_entry ? S_END : S_FETCH;
`endif
                end
            end
`ifdef PLAY_GAP_EN
            S_GAP: begin
                if (gap_last) begin
                    state_nx = S_FETCH;
                end
            end
`endif
            S_END:   state_nx = (loop && rec_len != '0) ? S_FETCH : S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (stop) begin
            state_nx = S_IDLE;
        end
    end

    // State, address walk and the registered sound-engine interface.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            addr       <= '0;
            snd_start  <= 1'b0;
            snd_abort  <= 1'b0;
            snd_octave <= '0;
            snd_note   <= '0;
            snd_length <= '0;
            cur_addr   <= '0;
        end else begin
            state     <= state_nx;
            snd_start <= 1'b0;
            snd_abort <= stop && (state == S_WAIT);
            if (aborting) begin
                addr <= '0;
            end else begin
                case (state)
                    S_LOAD: begin
                        if (entry_valid) begin
                            snd_octave <= rd_data[DW-2 -: OCT_W];
                            snd_note   <= rd_data[NOTE_W+LEN_W-1 -: NOTE_W];
                            snd_length <= rd_data[LEN_W-1:0];
                            snd_start  <= 1'b1;
                            cur_addr   <= addr;
                        end
                    end
                    S_WAIT: begin
                        if (snd_over && !last_entry) begin
                            addr <= addr + 1'b1;
                        end
                    end
                    S_END:   addr <= '0;
                    default: addr <= addr;
                endcase
            end
        end
    end

    // Note LEDs: one-hot of do..si while a note sounds, dark for rests and other states.
    always_comb begin
        note_led = 7'd0;
        if (state == S_WAIT && snd_note != '0) begin
            note_led = 7'd1 << (snd_note - 1'b1);
        end
    end

endmodule

// File: tb/tb_rec_player.sv
// tb/tb_rec_player.sv - randomized self-checking bench for rec_player
module tb_rec_player;

    localparam int OCT_W      = 2;
    localparam int NOTE_W     = 3;
    localparam int LEN_W      = 3;
    localparam int ADDR_W     = 5;
    localparam int GAP_CYCLES = 16;
    localparam int DW         = 1 + OCT_W + NOTE_W + LEN_W;
    localparam int DEPTH      = 1 << ADDR_W;
`ifdef PLAY_GAP_EN
    localparam int GAP_EXP    = GAP_CYCLES + 1;
`else
    localparam int GAP_EXP    = 1;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              play = 1'b0;
    logic              stop = 1'b0;
    logic              loop = 1'b0;
    logic              snd_over = 1'b0;
    logic [ADDR_W:0]   rec_len = '0;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DW-1:0]     rd_data = '0;
    logic              snd_start;
    logic              snd_abort;
    logic [OCT_W-1:0]  snd_octave;
    logic [NOTE_W-1:0] snd_note;
    logic [LEN_W-1:0]  snd_length;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] cur_addr;
    logic [6:0]        note_led;

    logic [DW-1:0]     mem [0:DEPTH-1];
    logic [6:0]        led_tab [0:7];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int n_start, n_done, n_abort, n_rd;
    int over_cnt, over_delay, over_cyc, led_bad;
    int first_start, first_done;
    int log_ent[$];
    int rd_log[$];
    int gap_log[$];
    int exp_ent[$];

    rec_player #(
        .OCT_W(OCT_W), .NOTE_W(NOTE_W), .LEN_W(LEN_W),
        .ADDR_W(ADDR_W), .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .play(play), .stop(stop), .loop(loop),
        .rec_len(rec_len), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .snd_start(snd_start), .snd_abort(snd_abort), .snd_octave(snd_octave),
        .snd_note(snd_note), .snd_length(snd_length), .snd_over(snd_over),
        .busy(busy), .done(done), .cur_addr(cur_addr), .note_led(note_led)
    );

    always #5 clk = ~clk;

    // Synchronous-read record RAM.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    task automatic clear_log();
        n_start = 0; n_done = 0; n_abort = 0; n_rd = 0;
        over_cnt = 0; over_cyc = -1; led_bad = 0;
        first_start = -1; first_done = -1;
        log_ent.delete(); rd_log.delete(); gap_log.delete();
    endtask

    // Reference: entries play in order from 0 until rec_len or the first invalid entry.
    task automatic build_expect(input int reps);
        exp_ent.delete();
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < int'(rec_len); i++) begin
                if (!mem[i][DW-1]) break;
                exp_ent.push_back((i << 8) | int'(mem[i][DW-2:0]));
            end
        end
    endtask

    task automatic fill_valid(input int n);
        for (int i = 0; i < DEPTH; i++) mem[i] = {1'b1, (DW-1)'($urandom)};
        for (int i = n; i < DEPTH; i++) mem[i] = {1'b0, (DW-1)'($urandom)};
    endtask

    // One clock: advance, release pulses, log what the DUT shows, play the Sound engine.
    task automatic step();
        @(posedge clk);
        #1;
        play = 1'b0; stop = 1'b0; snd_over = 1'b0;
        cyc++;
        if (rd_en) begin
            n_rd++;
            rd_log.push_back(int'(rd_addr));
            if (over_cyc >= 0) begin
                gap_log.push_back(cyc - over_cyc);
                over_cyc = -1;
            end
        end else if (over_cyc >= 0 && note_led != 7'd0) begin
            led_bad++;
        end
        if (done) begin
            n_done++;
            over_cyc = -1;
            if (first_done < 0) first_done = cyc;
        end
        if (snd_abort) n_abort++;
        if (snd_start) begin
            n_start++;
            if (first_start < 0) first_start = cyc;
            log_ent.push_back((int'(cur_addr) << 8) | int'({snd_octave, snd_note, snd_length}));
            n_cmp++;
            if (note_led !== led_tab[snd_note]) begin
                n_err++;
                $display("FAIL note_led got %b want %b", note_led, led_tab[snd_note]);
            end
            over_cnt = over_delay;
        end else if (over_cnt > 0) begin
            over_cnt--;
            if (over_cnt == 0) begin
                snd_over = 1'b1;
                over_cyc = cyc;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({rd_en, rd_addr, snd_start, snd_abort, snd_octave, snd_note, snd_length,
             busy, done, cur_addr, note_led} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got busy=%b rd_en=%b led=%b want all zero",
                     busy, rd_en, note_led);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step();
    endtask

    task automatic test_sequence(input int len, input int dly);
        int pcyc;
        rec_len = (ADDR_W+1)'(len);
        fill_valid(len);
        over_delay = dly;
        loop = 1'b0;
        clear_log();
        build_expect(1);
        play = 1'b1;
        pcyc = cyc;
        for (int k = 0; k < 40 * len + 20 && n_done == 0; k++) step();
        n_cmp++;
        if (n_done !== 1) begin
            n_err++; $display("FAIL seq_done got %0d want 1 (len %0d)", n_done, len);
        end
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++; $display("FAIL seq_busy_at_done got %b want 1", busy);
        end
        n_cmp++;
        if (first_start !== pcyc + 3) begin
            n_err++; $display("FAIL seq_latency got %0d want %0d", first_start - pcyc, 3);
        end
        n_cmp++;
        if (log_ent.size() !== exp_ent.size()) begin
            n_err++; $display("FAIL seq_count got %0d want %0d", log_ent.size(), exp_ent.size());
        end
        for (int i = 0; i < exp_ent.size() && i < log_ent.size(); i++) begin
            n_cmp++;
            if (log_ent[i] !== exp_ent[i]) begin
                n_err++; $display("FAIL seq_entry[%0d] got %h want %h", i, log_ent[i], exp_ent[i]);
            end
        end
        step();
        n_cmp++;
        if (busy !== 1'b0 || n_done !== 1) begin
            n_err++; $display("FAIL seq_idle got busy=%b done=%0d want 0/1", busy, n_done);
        end
    endtask

    task automatic test_empty();
        int pcyc;
        rec_len = '0;
        over_delay = 4;
        clear_log();
        play = 1'b1;
        pcyc = cyc;
        for (int k = 0; k < 10 && n_done == 0; k++) step();
        n_cmp++;
        if (first_done !== pcyc + 1) begin
            n_err++; $display("FAIL empty_done got %0d want %0d", first_done, pcyc + 1);
        end
        repeat (3) step();
        n_cmp++;
        if (n_rd !== 0 || n_start !== 0 || busy !== 1'b0) begin
            n_err++; $display("FAIL empty_quiet got rd=%0d start=%0d busy=%b want 0/0/0",
                              n_rd, n_start, busy);
        end
    endtask

    task automatic test_invalid();
        rec_len = 4;
        fill_valid(4);
        mem[2] = {1'b0, (DW-1)'($urandom)};
        over_delay = $urandom_range(1, 8);
        clear_log();
        build_expect(1);
        play = 1'b1;
        for (int k = 0; k < 100 && n_done == 0; k++) step();
        step();
        n_cmp++;
        if (n_start !== 2 || n_done !== 1 || n_rd !== 3) begin
            n_err++; $display("FAIL invalid_counts got start=%0d done=%0d rd=%0d want 2/1/3",
                              n_start, n_done, n_rd);
        end
        for (int i = 0; i < exp_ent.size() && i < log_ent.size(); i++) begin
            n_cmp++;
            if (log_ent[i] !== exp_ent[i]) begin
                n_err++; $display("FAIL invalid_entry[%0d] got %h want %h", i, log_ent[i], exp_ent[i]);
            end
        end
    endtask

    task automatic test_stop();
        rec_len = 4;
        fill_valid(4);
        over_delay = 10;
        clear_log();
        play = 1'b1;
        for (int k = 0; k < 80 && n_start < 2; k++) step();
        step();
        stop = 1'b1;
        step();
        over_cnt = 0;
        n_cmp++;
        if (snd_abort !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL stop_abort got abort=%b busy=%b want 1/0", snd_abort, busy);
        end
        repeat (5) step();
        n_cmp++;
        if (n_abort !== 1 || n_done !== 0 || n_start !== 2) begin
            n_err++; $display("FAIL stop_after got abort=%0d done=%0d start=%0d want 1/0/2",
                              n_abort, n_done, n_start);
        end
        clear_log();
        play = 1'b1;
        for (int k = 0; k < 10 && n_rd == 0; k++) step();
        n_cmp++;
        if (rd_log.size() == 0 || rd_log[0] !== 0) begin
            n_err++; $display("FAIL stop_restart got reads=%0d first=%0d want addr 0",
                              rd_log.size(), rd_log.size() ? rd_log[0] : -1);
        end
        stop = 1'b1;
        step();
        over_cnt = 0;
        n_cmp++;
        if (busy !== 1'b0 || snd_abort !== 1'b0) begin
            n_err++; $display("FAIL stop_fetch got busy=%b abort=%b want 0/0", busy, snd_abort);
        end
    endtask

    task automatic test_loop();
        rec_len = 2;
        fill_valid(2);
        loop = 1'b1;
        over_delay = $urandom_range(2, 10);
        clear_log();
        build_expect(2);
        play = 1'b1;
        for (int k = 0; k < 200 && n_done < 2; k++) step();
        stop = 1'b1;
        step();
        loop = 1'b0;
        over_cnt = 0;
        n_cmp++;
        if (busy !== 1'b0 || n_done !== 2 || n_abort !== 0) begin
            n_err++; $display("FAIL loop_stop got busy=%b done=%0d abort=%0d want 0/2/0",
                              busy, n_done, n_abort);
        end
        n_cmp++;
        if (log_ent.size() !== 4) begin
            n_err++; $display("FAIL loop_count got %0d want 4", log_ent.size());
        end
        for (int i = 0; i < exp_ent.size() && i < log_ent.size(); i++) begin
            n_cmp++;
            if (log_ent[i] !== exp_ent[i]) begin
                n_err++; $display("FAIL loop_entry[%0d] got %h want %h", i, log_ent[i], exp_ent[i]);
            end
        end
    endtask

    task automatic test_gap();
        rec_len = 3;
        fill_valid(3);
        mem[0] = {1'b1, 2'd1, 3'd3, 3'd2};
        over_delay = 5;
        clear_log();
        play = 1'b1;
        for (int k = 0; k < 150 && n_done == 0; k++) step();
        n_cmp++;
        if (gap_log.size() !== 2 || led_bad !== 0) begin
            n_err++; $display("FAIL gap_count got gaps=%0d led_bad=%0d want 2/0",
                              gap_log.size(), led_bad);
        end
        for (int i = 0; i < gap_log.size(); i++) begin
            n_cmp++;
            if (gap_log[i] !== GAP_EXP) begin
                n_err++; $display("FAIL gap_len[%0d] got %0d want %0d", i, gap_log[i], GAP_EXP);
            end
        end
        n_cmp++;
        if (log_ent.size() == 0 || log_ent[0] !== ((0 << 8) | 8'h5A)) begin
            n_err++; $display("FAIL gap_entry0 got %h want 05a", log_ent.size() ? log_ent[0] : -1);
        end
        step();
    endtask

    task automatic test_async_reset();
        rec_len = 3;
        fill_valid(3);
        over_delay = 10;
        clear_log();
        play = 1'b1;
        for (int k = 0; k < 20 && n_start == 0; k++) step();
        step();
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy, snd_start, note_led, cur_addr, rd_en} !== '0) begin
            n_err++; $display("FAIL async_reset got busy=%b led=%b want 0", busy, note_led);
        end
        #2 rst = 1'b0;
        over_cnt = 0;
        step();
    endtask

    initial begin
        led_tab = '{7'h00, 7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h40};
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        clear_log();
        over_delay = 10;
        test_reset();
        test_sequence(3, 10);
        for (int t = 0; t < 3; t++) test_sequence($urandom_range(1, 6), $urandom_range(1, 12));
        test_sequence(DEPTH, 2);
        test_empty();
        test_invalid();
        test_stop();
        test_loop();
        test_gap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
